// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode numbering, sequencer state encoding and opcode classes for the hardwired control unit.
package cpu_ctrl_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_AND  = 2;
    localparam int OP_OR   = 3;
    localparam int OP_SHR  = 4;
    localparam int OP_SHL  = 5;
    localparam int OP_ROR  = 6;
    localparam int OP_ROL  = 7;
    localparam int OP_ADDI = 8;
    localparam int OP_ANDI = 9;
    localparam int OP_ORI  = 10;
    localparam int OP_LD   = 11;
    localparam int OP_ST   = 12;
    localparam int OP_MUL  = 13;
    localparam int OP_DIV  = 14;
    localparam int OP_JR   = 15;
    localparam int OP_JAL  = 16;
    localparam int OP_NOP  = 17;
    localparam int OP_HALT = 18;

    // Encoding doubles as the debug step index.
    typedef enum logic [3:0] {
        S_T0      = 4'd0,
        S_T1      = 4'd1,
        S_T2      = 4'd2,
        S_T3      = 4'd3,
        S_T4      = 4'd4,
        S_T5      = 4'd5,
        S_T6      = 4'd6,
        S_T7      = 4'd7,
        S_STOPPED = 4'd14,
        S_HALT    = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        ALU_R, ALU_I, LD, ST, MULDIV, JR, JAL, NOP, HALT, ILL
    } op_class_t;

endpackage

// File: rtl/control_sequencer_op_classify.sv
// Combinational opcode decoder: instruction class plus the ALU operation an immediate form maps onto.
module op_classify
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] op,
    output op_class_t           cls,
    output logic [OPCODE_W-1:0] base_op
);

    always_comb begin
        cls     = ILL;
        base_op = op;
        case (int'(op))
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = ALU_R;
            OP_ADDI: begin cls = ALU_I; base_op = OPCODE_W'(OP_ADD); end
            OP_ANDI: begin cls = ALU_I; base_op = OPCODE_W'(OP_AND); end
            OP_ORI:  begin cls = ALU_I; base_op = OPCODE_W'(OP_OR);  end
            OP_LD:            cls = LD;
            OP_ST:            cls = ST;
            OP_MUL, OP_DIV:   cls = MULDIV;
            OP_JR:            cls = JR;
            OP_JAL:           cls = JAL;
            OP_NOP:           cls = NOP;
            OP_HALT:          cls = HALT;
            default:          cls = ILL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-step control sequencer: fetch, decode, then per-class execute strobes for the datapath.
// Memory steps stall on mem_ready or a fixed latency; stop pauses at instruction boundaries, HALT until clear.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W      = 5,
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_LATENCY   = 1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                mem_ready,
    input  logic                stop,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                PCin,
    output logic                Read,
    output logic                Write,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                Cout,
    output logic                HIin,
    output logic                LOin,
    output logic                R8_RAin,
    output logic [OPCODE_W-1:0] opcode,
    output logic                run,
    output logic                illegal,
    output logic [3:0]          step
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t              state, state_nxt, fin_state;
    op_class_t           cls;
    logic [OPCODE_W-1:0] base_op;
    logic [CNT_W-1:0]    cnt;
    logic                armed, mem_done;

    op_classify #(.OPCODE_W(OPCODE_W)) u_classify (
        .op      (ir_opcode),
        .cls     (cls),
        .base_op (base_op)
    );

    // cnt counts cycles spent in the current step; it saturates so a long handshake wait never re-fires first-cycle strobes.
    assign mem_done  = (MEM_HANDSHAKE != 0) ? mem_ready : (cnt == CNT_W'(MEM_LATENCY - 1));
    assign fin_state = stop ? S_STOPPED : S_T0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_T0: state_nxt = S_T1;
            S_T1: if (mem_done) state_nxt = S_T2;
            S_T2: state_nxt = S_T3;
            S_T3: begin
                case (cls)
                    HALT:                            state_nxt = S_HALT;
                    ALU_R, ALU_I, LD, ST, MULDIV, JAL: state_nxt = S_T4;
                    default:                         state_nxt = fin_state;
                endcase
            end
            S_T4: state_nxt = (cls == JAL) ? fin_state : S_T5;
            S_T5: state_nxt = (cls == LD || cls == ST || cls == MULDIV) ? S_T6 : fin_state;
            S_T6: begin
                if (cls == ST || (cls == LD && mem_done)) state_nxt = S_T7;
                else if (cls != LD)                       state_nxt = fin_state;
            end
            S_T7: if (cls != ST || mem_done) state_nxt = fin_state;
            S_STOPPED: if (!stop) state_nxt = S_T0;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_T0;
        endcase
    end

    // armed keeps the strobes quiet for the first cycle out of reset before T0 starts driving them.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= S_T0;
            cnt     <= '0;
            armed   <= 1'b0;
            illegal <= 1'b0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);
            if (state == S_T3 && cls == ILL)
                illegal <= 1'b1;
        end
    end

    assign run  = (state != S_HALT) && (state != S_STOPPED);
    assign step = state;

    always_comb begin
        {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, Write, MDRin, MDRout, IRin,
         Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, HIin, LOin, R8_RAin} = '0;
        opcode = '0;
        if (armed) begin
            case (state)
                S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
                S_T1: begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                    if (cnt == '0) begin Zlowout = 1'b1; PCin = 1'b1; end
                end
                S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
                S_T3: begin
                    case (cls)
                        ALU_R, ALU_I: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        LD, ST:       begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                        MULDIV:       begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        JR:           begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        JAL:          begin PCout = 1'b1; R8_RAin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (cls)
                        ALU_R:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = base_op; end
                        ALU_I:  begin Cout = 1'b1; Zin = 1'b1; opcode = base_op; end
                        LD, ST: begin Cout = 1'b1; Zin = 1'b1; opcode = OPCODE_W'(OP_ADD); end
                        MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = ir_opcode; end
                        JAL:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (cls)
                        ALU_R, ALU_I: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        LD, ST:       begin Zlowout = 1'b1; MARin = 1'b1; end
                        MULDIV:       begin Zlowout = 1'b1; LOin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (cls)
                        LD:     begin Read = 1'b1; MDRin = 1'b1; end
                        ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                        MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T7: begin
                    if (cls == LD)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    else if (cls == ST) Write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
